// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus rise/fall pulses.
// Flops reset to 1 so that an idle (pulled-up) bus produces no edge after reset.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw pin through the chain; remember last synchronized level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: START/STOP detection, 7-bit address match, write bytes out on
// rx_*, read bytes served from tx_data. SDA is only ever pulled low or released.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h55,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2c_scl,
    inout  wire                   i2c_sda,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    output logic                  rw,
    output logic                  busy,
    output logic                  stop_det
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(reset), .din(i2c_scl),
        .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(reset), .din(i2c_sda),
        .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    // Bus conditions: SDA moving while SCL is (still) high.
    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;

    i2c_tgt_state_t        state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  done_q, done_d;      // 8th bit seen (or ACK seen in RD_ACK)
    logic                  sda_low_q, sda_low_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  stop_det_q, stop_det_d;

    // Next-state logic; STOP/START pre-empt any SCL edge in the same clock.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
        sda_low_d  = sda_low_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        stop_det_d = 1'b0;

        if (stop_cond) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            done_d     = 1'b0;
            sda_low_d  = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_cond) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            done_d    = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_d[7:1] == SLAVE_ADDR) done_d = 1'b1;
                            else                            state_d = ST_IDLE;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        sda_low_d = I2C_ACK == 1'b0;
                        rw_d      = shift_q[0];
                        busy_d    = 1'b1;
                        state_d   = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            shift_d   = tx_data;
                            sda_low_d = ~tx_data[7];
                            tx_req_d  = 1'b1;
                            state_d   = ST_RD_BYTE;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shift_d;
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        sda_low_d = 1'b1;
                        state_d   = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d    = 1'b0;
                            sda_low_d = 1'b0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            // Rotate so the next bit lands in bit 7.
                            shift_d   = {shift_q[6:0], shift_q[7]};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        shift_d   = tx_data;
                        sda_low_d = ~tx_data[7];
                        tx_req_d  = 1'b1;
                        state_d   = ST_RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; async reset also releases SDA immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            sda_low_q  <= sda_low_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            stop_det_q <= stop_det_d;
        end
    end

    assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rw       = rw_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule
